regfile_port_arbiter: RTL and testbench

Access controller in front of the 8 x 24-bit register file. It shares the file's single access slot per cycle between a writeback requester and an operand-read requester. The file reads only when its write enable is low, so each cycle is either one write or one read. After reset the block clears r1..r7, because the register file itself has no reset. It sits between the decode/writeback stages and the register file and is the only driver of the file's address, data and write-enable inputs.

---
 rtl/regfile_arb_pkg.sv | 21 ++
 rtl/regfile_port_arbiter_if.sv | 29 ++
 rtl/regfile_arb_grant.sv | 54 +++++
 rtl/regfile_port_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_port_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
package regfile_arb_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int ADDR_W_DEF = 3;
    localparam int REG_COUNT  = 8;
    localparam int LAST_REG   = 7;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD,
        GNT_WR,
        GNT_WR0_RD
    } gnt_e;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side bus of the arbiter: operand-read and writeback handshakes.
interface regfile_port_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_rs;
    logic [ADDR_W-1:0] rd_rt;
    logic              rd_rsp_valid;
    logic [DATA_W-1:0] rd_rsp_a;
    logic [DATA_W-1:0] rd_rsp_b;
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_rd;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_req_valid, rd_rs, rd_rt, wr_req_valid, wr_rd, wr_data,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_a, rd_rsp_b, wr_req_ready
    );

    modport slave (
        input  rd_req_valid, rd_rs, rd_rt, wr_req_valid, wr_rd, wr_data,
        output rd_req_ready, rd_rsp_valid, rd_rsp_a, rd_rsp_b, wr_req_ready
    );
endinterface

// File: rtl/regfile_arb_grant.sv
// Combinational slot decision between writeback and operand read.
// Build option REGFILE_RAW_PRIO_EN: a write aliasing a pending read's source beats starvation.
module regfile_arb_grant
    import regfile_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  state_e            state_i,
    input  logic              rd_valid_i,
    input  logic [ADDR_W-1:0] rd_rs_i,
    input  logic [ADDR_W-1:0] rd_rt_i,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_rd_i,
    input  logic [3:0]        starve_cnt_i,
    output gnt_e              gnt_o,
    output logic              rd_ready_o,
    output logic              wr_ready_o
);
    logic wr_real;
    logic wr_zero;
    logic starved;
    logic raw_hit;

    assign wr_real = wr_valid_i && (wr_rd_i != '0);
    assign wr_zero = wr_valid_i && (wr_rd_i == '0);
    assign starved = (starve_cnt_i == 4'(STARVE_MAX));

`ifdef REGFILE_RAW_PRIO_EN
    assign raw_hit = (wr_rd_i == rd_rs_i) || (wr_rd_i == rd_rt_i);
`else
    // Read addresses only matter for the hazard check of the other build.
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_rs_i, rd_rt_i};
    assign raw_hit        = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_o      = GNT_NONE;
        rd_ready_o = 1'b0;
        wr_ready_o = 1'b0;
        if (state_i == RUN) begin
            if (wr_real && !(rd_valid_i && starved && !raw_hit)) begin
                gnt_o = GNT_WR;
            end else if (rd_valid_i) begin
                gnt_o = wr_zero ? GNT_WR0_RD : GNT_RD;
            end
            rd_ready_o = (gnt_o == GNT_RD) || (gnt_o == GNT_WR0_RD);
            // A write to r0 is swallowed without taking the slot.
            wr_ready_o = (gnt_o == GNT_WR) || wr_zero;
        end
    end
endmodule

// File: rtl/regfile_port_arbiter.sv
// Single-slot access controller for the 8 x 24-bit register file; clears r1..r7 after reset.
// Build option REGFILE_RAW_PRIO_EN (see regfile_arb_grant).
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_port_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0]      rf_rs,
    output logic [ADDR_W-1:0]      rf_rt,
    output logic [ADDR_W-1:0]      rf_rd,
    output logic [DATA_W-1:0]      rf_dataIn,
    output logic                   rf_we,
    input  logic [DATA_W-1:0]      rf_dataOutA,
    input  logic [DATA_W-1:0]      rf_dataOutB,
    output logic                   busy
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;

    gnt_e gnt;
    logic rd_ready;
    logic wr_ready;
    logic rd_hs;

    regfile_arb_grant #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .state_i      (state_q),
        .rd_valid_i   (bus.rd_req_valid),
        .rd_rs_i      (bus.rd_rs),
        .rd_rt_i      (bus.rd_rt),
        .wr_valid_i   (bus.wr_req_valid),
        .wr_rd_i      (bus.wr_rd),
        .starve_cnt_i (starve_cnt_q),
        .gnt_o        (gnt),
        .rd_ready_o   (rd_ready),
        .wr_ready_o   (wr_ready)
    );

    assign rd_hs = bus.rd_req_valid && rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            init_ptr_q   <= ADDR_W'(1);
            starve_cnt_q <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of order.
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        starve_cnt_d = starve_cnt_q;
        rsp_valid_d  = rd_hs;
        if (state_q == INIT) begin
            if (init_ptr_q == ADDR_W'(LAST_REG)) begin
                state_d = RUN;
            end else begin
                init_ptr_d = init_ptr_q + ADDR_W'(1);
            end
        end
        if (!bus.rd_req_valid || rd_hs) begin
            starve_cnt_d = '0;
        end else if ((gnt == GNT_WR) && (starve_cnt_q != 4'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        rf_we     = 1'b0;
        rf_rs     = bus.rd_rs;
        rf_rt     = bus.rd_rt;
        rf_rd     = bus.wr_rd;
        rf_dataIn = bus.wr_data;
        if (state_q == INIT) begin
            // NOTE: the file has no reset of its own, so its contents are cleared by writing zeros.
            // rf_we is gated by rst_n so the file is never written while reset is held.
            rf_we     = rst_n;
            rf_rd     = init_ptr_q;
            rf_dataIn = '0;
        end else begin
            rf_we = (gnt == GNT_WR);
        end
    end

    assign busy             = (state_q == INIT);
    assign bus.rd_req_ready = rd_ready;
    assign bus.wr_req_ready = wr_ready;
    assign bus.rd_rsp_valid = rsp_valid_q;
    assign bus.rd_rsp_a     = rsp_valid_q ? rf_dataOutA : '0;
    assign bus.rd_rsp_b     = rsp_valid_q ? rf_dataOutB : '0;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench: register-file model, vector table for grants, scoreboard for read data.
module tb_regfile_port_arbiter;
    import regfile_arb_pkg::*;

    localparam int DW = 24;
    localparam int AW = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rf_rs, rf_rt, rf_rd;
    logic [DW-1:0] rf_dataIn;
    logic          rf_we;
    logic [DW-1:0] rf_dataOutA, rf_dataOutB;
    logic          busy;

    regfile_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rf_rs       (rf_rs),
        .rf_rt       (rf_rt),
        .rf_rd       (rf_rd),
        .rf_dataIn   (rf_dataIn),
        .rf_we       (rf_we),
        .rf_dataOutA (rf_dataOutA),
        .rf_dataOutB (rf_dataOutB),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Register file: no reset, r0 reads zero, registered reads only when rf_we is low.
    logic [DW-1:0] mem [REG_COUNT];
    initial for (int i = 0; i < REG_COUNT; i++) mem[i] = 24'hA5A500 | 24'(i);
    always @(posedge clk) begin
        if (rf_we) begin
            if (rf_rd != '0) mem[rf_rd] <= rf_dataIn;
        end else begin
            rf_dataOutA <= (rf_rs == '0) ? '0 : mem[rf_rs];
            rf_dataOutB <= (rf_rt == '0) ? '0 : mem[rf_rt];
        end
    end

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } rsp_t;

    typedef struct {
        logic          rv;
        logic [AW-1:0] rs, rt;
        logic          wv;
        logic [AW-1:0] wrd;
        logic [DW-1:0] wd;
        logic          err, ewr, ewe;
    } vec_t;

    rsp_t          sb [$];
    logic [DW-1:0] ref_regs [REG_COUNT];
    vec_t          vecs [21];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rv, input int rs, input int rt, input logic wv,
                               input int wrd, input logic [DW-1:0] wd,
                               input logic err, input logic ewr, input logic ewe);
        vec_t r;
        r.rv = rv; r.rs = AW'(rs); r.rt = AW'(rt);
        r.wv = wv; r.wrd = AW'(wrd); r.wd = wd;
        r.err = err; r.ewr = ewr; r.ewe = ewe;
        return r;
    endfunction

    task automatic drive(input logic rv, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic wv, input logic [AW-1:0] wrd, input logic [DW-1:0] wd);
        bus.rd_req_valid = rv;
        bus.rd_rs        = rs;
        bus.rd_rt        = rt;
        bus.wr_req_valid = wv;
        bus.wr_rd        = wrd;
        bus.wr_data      = wd;
    endtask

    task automatic check_rsp(input string tag);
        rsp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " rsp_valid"}, 32'(bus.rd_rsp_valid), 32'd1);
            check({tag, " rsp_a"}, 32'(bus.rd_rsp_a), 32'(e.a));
            check({tag, " rsp_b"}, 32'(bus.rd_rsp_b), 32'(e.b));
        end else begin
            check({tag, " rsp_valid idle"}, 32'(bus.rd_rsp_valid), 32'd0);
            check({tag, " rsp_a idle"}, 32'(bus.rd_rsp_a), 32'd0);
        end
    endtask

    // One RUN cycle: check last response, drive, then check grant outputs before the edge.
    task automatic step(input string tag, input vec_t x);
        @(negedge clk);
        check_rsp(tag);
        drive(x.rv, x.rs, x.rt, x.wv, x.wrd, x.wd);
        #1;
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " rd_ready"}, 32'(bus.rd_req_ready), 32'(x.err));
        check({tag, " wr_ready"}, 32'(bus.wr_req_ready), 32'(x.ewr));
        check({tag, " rf_we"}, 32'(rf_we), 32'(x.ewe));
        if (x.ewe) begin
            check({tag, " rf_rd"}, 32'(rf_rd), 32'(x.wrd));
            check({tag, " rf_dataIn"}, 32'(rf_dataIn), 32'(x.wd));
        end
        if (x.err) begin
            check({tag, " rf_rs"}, 32'(rf_rs), 32'(x.rs));
            check({tag, " rf_rt"}, 32'(rf_rt), 32'(x.rt));
            sb.push_back('{a: ref_regs[x.rs], b: ref_regs[x.rt]});
        end
        if (x.ewr && (x.wrd != '0)) ref_regs[x.wrd] = x.wd;
    endtask

    // Release reset and follow the seven clearing writes while requests are held pending.
    task automatic run_init(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= LAST_REG; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            check($sformatf("%s%0d busy", tag, k), 32'(busy), 32'd1);
            check($sformatf("%s%0d rf_we", tag, k), 32'(rf_we), 32'd1);
            check($sformatf("%s%0d rf_rd", tag, k), 32'(rf_rd), 32'(k));
            check($sformatf("%s%0d rf_dataIn", tag, k), 32'(rf_dataIn), 32'd0);
            check($sformatf("%s%0d rd_ready", tag, k), 32'(bus.rd_req_ready), 32'd0);
            check($sformatf("%s%0d wr_ready", tag, k), 32'(bus.wr_req_ready), 32'd0);
        end
        for (int i = 0; i < REG_COUNT; i++) ref_regs[i] = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " rf_we"}, 32'(rf_we), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " rd_ready"}, 32'(bus.rd_req_ready), 32'd0);
        check({tag, " wr_ready"}, 32'(bus.wr_req_ready), 32'd0);
        check({tag, " rsp_valid"}, 32'(bus.rd_rsp_valid), 32'd0);
        check({tag, " rsp_a"}, 32'(bus.rd_rsp_a), 32'd0);
        check({tag, " rsp_b"}, 32'(bus.rd_rsp_b), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = v(0, 0, 0, 1, 3, 24'hABCDEF, 0, 1, 1);
        vecs[1]  = v(1, 3, 0, 0, 0, 24'h000000, 1, 0, 0);
        vecs[2]  = v(0, 0, 0, 0, 0, 24'h000000, 0, 0, 0);
        vecs[3]  = v(0, 0, 0, 1, 5, 24'h000011, 0, 1, 1);
        vecs[4]  = v(1, 3, 5, 1, 4, 24'h111111, 0, 1, 1);
        vecs[5]  = v(1, 3, 5, 1, 6, 24'h222222, 0, 1, 1);
        vecs[6]  = v(1, 3, 5, 1, 4, 24'h333333, 0, 1, 1);
        vecs[7]  = v(1, 3, 5, 1, 6, 24'h444444, 1, 0, 0);
        vecs[8]  = v(1, 3, 5, 1, 6, 24'h444444, 0, 1, 1);
        vecs[9]  = v(1, 3, 5, 1, 4, 24'h555555, 0, 1, 1);
        vecs[10] = v(1, 3, 5, 1, 6, 24'h666666, 0, 1, 1);
        vecs[11] = v(1, 3, 5, 1, 4, 24'h777777, 1, 0, 0);
        vecs[12] = v(1, 0, 4, 1, 0, 24'h123456, 1, 1, 0);
        vecs[13] = v(0, 0, 0, 0, 0, 24'h000000, 0, 0, 0);
        vecs[14] = v(1, 5, 3, 1, 6, 24'h0A0A0A, 0, 1, 1);
        vecs[15] = v(1, 5, 3, 1, 6, 24'h0B0B0B, 0, 1, 1);
        vecs[16] = v(1, 5, 3, 1, 6, 24'h0C0C0C, 0, 1, 1);
`ifdef REGFILE_RAW_PRIO_EN
        vecs[17] = v(1, 5, 3, 1, 5, 24'h00BEEF, 0, 1, 1);
        vecs[18] = v(1, 5, 3, 0, 0, 24'h000000, 1, 0, 0);
`else
        vecs[17] = v(1, 5, 3, 1, 5, 24'h00BEEF, 1, 0, 0);
        vecs[18] = v(0, 0, 0, 1, 5, 24'h00BEEF, 0, 1, 1);
`endif
        vecs[19] = v(1, 5, 6, 0, 0, 24'h000000, 1, 0, 0);
        vecs[20] = v(0, 0, 0, 0, 0, 24'h000000, 0, 0, 0);

        // Reset held with both requesters asking.
        drive(1'b1, 3'd1, 3'd2, 1'b1, 3'd3, 24'h777777);
        @(negedge clk);
        @(negedge clk);
        check_reset("por");

        run_init("init");
        step("init_rd", v(1, 1, 2, 0, 0, 24'h0, 1, 0, 0));

        for (int i = 0; i < 21; i++) step($sformatf("v%0d", i), vecs[i]);

        // Reset asserted right after a read handshake: the response must never appear.
        step("mid_rd", v(1, 3, 5, 0, 0, 24'h0, 1, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        sb.delete();
        drive(1'b1, 3'd3, 3'd5, 1'b1, 3'd2, 24'h999999);
        @(negedge clk);
        check_reset("mid_hold");
        run_init("reinit");
        step("post_rd", v(1, 3, 5, 0, 0, 24'h0, 1, 0, 0));
        step("post_idle", v(0, 0, 0, 0, 0, 24'h0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
